wb_arb_2m1s: RTL

WB_ARB_2M1S -- requirements
Module: wb_arb_2m1s

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_timeout_cnt.sv | 26 ++
 rtl/wb_arb_2m1s.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone constants and the 2-master arbiter state encoding.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_M2 = 2'd1,
    ST_GNT_M3 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Slave-ack wait counter: counts stalled strobe cycles, flags when TIMEOUT is reached.
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WB_CNT_WIDTH-1:0] LIMIT = WB_CNT_WIDTH'(TIMEOUT);

  logic [WB_CNT_WIDTH-1:0] cnt;

  // clear has priority so a cycle that both stalls and expires restarts at zero
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (inc)     cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/wb_arb_2m1s.sv
// Two-master (D-cache m2, I-cache m3) to one-slave Wishbone arbiter with
// round-robin tie-break, one idle cycle between tenures and an ack timeout.
module wb_arb_2m1s
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m2_wbd_adr_i,
  input  logic [DATA_WIDTH-1:0]   m2_wbd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m2_wbd_sel_i,
  input  logic                    m2_wbd_we_i,
  input  logic                    m2_wbd_cyc_i,
  input  logic                    m2_wbd_stb_i,
  output logic [DATA_WIDTH-1:0]   m2_wbd_dat_o,
  output logic                    m2_wbd_ack_o,
  output logic                    m2_wbd_err_o,
  input  logic [ADDR_WIDTH-1:0]   m3_wbd_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m3_wbd_sel_i,
  input  logic                    m3_wbd_we_i,
  input  logic                    m3_wbd_cyc_i,
  input  logic                    m3_wbd_stb_i,
  output logic [DATA_WIDTH-1:0]   m3_wbd_dat_o,
  output logic                    m3_wbd_ack_o,
  output logic                    m3_wbd_err_o,
  output logic [ADDR_WIDTH-1:0]   s1_wbd_adr_o,
  output logic [DATA_WIDTH-1:0]   s1_wbd_dat_o,
  output logic [DATA_WIDTH/8-1:0] s1_wbd_sel_o,
  output logic                    s1_wbd_we_o,
  output logic                    s1_wbd_cyc_o,
  output logic                    s1_wbd_stb_o,
  input  logic [DATA_WIDTH-1:0]   s1_wbd_dat_i,
  input  logic                    s1_wbd_ack_i,
  output logic [1:0]              dbg_state
);

  // Handshake: a master holds cyc for its whole tenure; each stb is a request
  // that completes when ack (or err on timeout) is returned the same cycle.

  arb_state_t state, state_next;
  logic       rr, rr_next;
  logic       granted, owner_cyc, owner_stb;
  logic       expired, timeout, cnt_clr, cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_next;
      rr    <= rr_next;
    end
  end

  always_comb begin
    state_next = state;
    rr_next    = rr;
    case (state)
      ST_IDLE: begin
        if (m2_wbd_cyc_i && m3_wbd_cyc_i) state_next = rr ? ST_GNT_M3 : ST_GNT_M2;
        else if (m2_wbd_cyc_i)            state_next = ST_GNT_M2;
        else if (m3_wbd_cyc_i)            state_next = ST_GNT_M3;
      end
      ST_GNT_M2: begin
        if (!m2_wbd_cyc_i) begin
          state_next = ST_IDLE;
          rr_next    = 1'b1;
        end
      end
      ST_GNT_M3: begin
        if (!m3_wbd_cyc_i) begin
          state_next = ST_IDLE;
          rr_next    = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign granted   = (state == ST_GNT_M2) || (state == ST_GNT_M3);
  assign owner_cyc = (state == ST_GNT_M2) ? m2_wbd_cyc_i :
                     (state == ST_GNT_M3) ? m3_wbd_cyc_i : 1'b0;
  assign owner_stb = (state == ST_GNT_M2) ? m2_wbd_stb_i :
                     (state == ST_GNT_M3) ? m3_wbd_stb_i : 1'b0;

  // A slave ack in the expiry cycle completes the access instead of erroring.
  assign timeout = granted && owner_stb && expired && !s1_wbd_ack_i;
  assign cnt_clr = !granted || !owner_stb || s1_wbd_ack_i || timeout;
  assign cnt_inc = granted && owner_stb && !s1_wbd_ack_i;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (expired)
  );

  always_comb begin
    s1_wbd_adr_o = '0;
    s1_wbd_dat_o = '0;
    s1_wbd_sel_o = '0;
    s1_wbd_we_o  = 1'b0;
    s1_wbd_cyc_o = 1'b0;
    s1_wbd_stb_o = 1'b0;
    m2_wbd_dat_o = '0;
    m2_wbd_ack_o = 1'b0;
    m2_wbd_err_o = 1'b0;
    m3_wbd_dat_o = '0;
    m3_wbd_ack_o = 1'b0;
    m3_wbd_err_o = 1'b0;
    case (state)
      ST_GNT_M2: begin
        s1_wbd_adr_o = m2_wbd_adr_i;
        s1_wbd_dat_o = m2_wbd_dat_i;
        s1_wbd_sel_o = m2_wbd_sel_i;
        s1_wbd_we_o  = m2_wbd_we_i;
        s1_wbd_cyc_o = m2_wbd_cyc_i && !timeout;
        s1_wbd_stb_o = m2_wbd_stb_i && !timeout;
        m2_wbd_dat_o = s1_wbd_dat_i;
        m2_wbd_ack_o = s1_wbd_ack_i;
        m2_wbd_err_o = timeout;
      end
      ST_GNT_M3: begin
        // I-cache is read-only: no write data and write-enable held low
        s1_wbd_adr_o = m3_wbd_adr_i;
        s1_wbd_sel_o = m3_wbd_sel_i;
        s1_wbd_cyc_o = m3_wbd_cyc_i && !timeout;
        s1_wbd_stb_o = m3_wbd_stb_i && !timeout;
        m3_wbd_dat_o = s1_wbd_dat_i;
        m3_wbd_ack_o = s1_wbd_ack_i;
        m3_wbd_err_o = timeout;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule
